// File: rtl/fpu_rnd_pkg.sv
// Shared constants and pipeline payload types for the FPU significand rounding path.
package fpu_rnd_pkg;

  localparam logic [1:0] RM_RU  = 2'b00;
  localparam logic [1:0] RM_RD  = 2'b01;
  localparam logic [1:0] RM_RZ  = 2'b10;
  localparam logic [1:0] RM_RNE = 2'b11;

  localparam int unsigned EMAX_DBL = 2047;
  localparam int unsigned EMAX_SGL = 255;
  localparam int unsigned SGL_LSB  = 31;

  typedef struct packed {
    logic        s;
    logic [12:0] e2;
    logic [1:0]  rm;
    logic        db;
    logic        inx;
    logic        carry;
    logic [52:0] sum;
  } st1_t;

  typedef struct packed {
    logic        s;
    logic [10:0] e3;
    logic [52:0] f3;
    logic [1:0]  rm;
    logic        db;
    logic        ovf;
    logic        inx;
  } st2_t;

endpackage

// File: rtl/rnd_decide.sv
// Round-position bit extraction and increment decision for single/double significands.
module rnd_decide
  import fpu_rnd_pkg::*;
(
  input  logic        i_s,
  input  logic [1:0]  i_rm,
  input  logic        i_db,
  input  logic [54:0] i_f2,
  output logic        o_guard,
  output logic        o_sticky,
  output logic        o_inc
);

  logic w_lsb;

  always_comb begin
    if (i_db) begin
      w_lsb    = i_f2[2];
      o_guard  = i_f2[1];
      o_sticky = i_f2[0];
    end else begin
      w_lsb    = i_f2[SGL_LSB];
      o_guard  = i_f2[SGL_LSB-1];
      o_sticky = |i_f2[SGL_LSB-2:0];
    end
  end

  always_comb begin
    o_inc = 1'b0;
    unique case (i_rm)
      RM_RNE:  o_inc = o_guard & (w_lsb | o_sticky);
      RM_RZ:   o_inc = 1'b0;
      RM_RU:   o_inc = ~i_s & (o_guard | o_sticky);
      RM_RD:   o_inc = i_s & (o_guard | o_sticky);
      default: o_inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/sigrnd_pipe.sv
// Two-stage significand rounder: stage 1 adds the increment, stage 2 post-normalizes
// and flags overflow; valid/ready handshake with no bubbles on simultaneous drain/fill.
module sigrnd_pipe
  import fpu_rnd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        s,
  input  logic [12:0] e2,
  input  logic [54:0] f2,
  input  logic [1:0]  RM_in,
  input  logic        db_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        s_out,
  output logic [10:0] e3,
  output logic [52:0] f3,
  output logic [1:0]  RM,
  output logic        db,
  output logic        OVF,
  output logic        INX
);

  logic        r_v1, r_v2;
  st1_t        r_s1;
  st2_t        r_s2;

  logic        w_r1, w_r2;
  logic        w_guard, w_sticky, w_inc;
  logic [52:0] w_kept;
  logic [53:0] w_inc_vec;
  logic [53:0] w_sum;
  st1_t        w_s1_d;
  logic [12:0] w_e;
  st2_t        w_s2_d;

  assign w_r2     = ~r_v2 | out_ready;
  assign w_r1     = ~r_v1 | w_r2;
  assign in_ready = w_r1;

  rnd_decide u_rnd_decide (
    .i_s      (s),
    .i_rm     (RM_in),
    .i_db     (db_in),
    .i_f2     (f2),
    .o_guard  (w_guard),
    .o_sticky (w_sticky),
    .o_inc    (w_inc)
  );

  // Single keeps 24 bits; the lower 29 are zeroed so the add lands at f2[31].
  assign w_kept    = db_in ? f2[54:2] : {f2[54:31], 29'b0};
  assign w_inc_vec = db_in ? 54'd1 : (54'd1 << (SGL_LSB - 2));
  assign w_sum     = {1'b0, w_kept} + (w_inc ? w_inc_vec : 54'd0);

  always_comb begin
    w_s1_d       = '0;
    w_s1_d.s     = s;
    w_s1_d.e2    = e2;
    w_s1_d.rm    = RM_in;
    w_s1_d.db    = db_in;
    w_s1_d.inx   = w_guard | w_sticky;
    w_s1_d.carry = w_sum[53];
    w_s1_d.sum   = w_sum[52:0];
  end

  // Carry-out means the sum is exactly 10.000..0, so the shifted significand is 1.000..0.
  assign w_e = r_s1.e2 + {12'b0, r_s1.carry};

  always_comb begin
    w_s2_d     = '0;
    w_s2_d.s   = r_s1.s;
    w_s2_d.rm  = r_s1.rm;
    w_s2_d.db  = r_s1.db;
    w_s2_d.inx = r_s1.inx;
    w_s2_d.f3  = r_s1.carry ? {1'b1, r_s1.sum[52:1]} : r_s1.sum;
    if (r_s1.db) begin
      w_s2_d.e3  = w_e[10:0];
      w_s2_d.ovf = ~w_e[12] & (w_e >= 13'(EMAX_DBL));
    end else begin
      w_s2_d.e3  = {3'b0, w_e[7:0]};
      w_s2_d.ovf = ~w_e[12] & (w_e >= 13'(EMAX_SGL));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else begin
      if (w_r1) r_v1 <= in_valid;
      if (in_valid && w_r1) r_s1 <= w_s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_s2 <= '0;
    end else begin
      if (w_r2) r_v2 <= r_v1;
      if (r_v1 && w_r2) r_s2 <= w_s2_d;
    end
  end

  assign out_valid = r_v2;
  assign s_out     = r_s2.s;
  assign e3        = r_s2.e3;
  assign f3        = r_s2.f3;
  assign RM        = r_s2.rm;
  assign db        = r_s2.db;
  assign OVF       = r_s2.ovf;
  assign INX       = r_s2.inx;

endmodule

// File: tb/tb_sigrnd_pipe.sv
// Directed and randomized scoreboard bench for sigrnd_pipe.
module tb_sigrnd_pipe;

  typedef struct packed {
    logic        s;
    logic [10:0] e3;
    logic [52:0] f3;
    logic [1:0]  rm;
    logic        db;
    logic        ovf;
    logic        inx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        s;
  logic [12:0] e2;
  logic [54:0] f2;
  logic [1:0]  RM_in;
  logic        db_in;
  logic        out_valid;
  logic        out_ready;
  logic        s_out;
  logic [10:0] e3;
  logic [52:0] f3;
  logic [1:0]  RM;
  logic        db;
  logic        OVF;
  logic        INX;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  bit   stall = 1'b0;
  exp_t snap;
  bit   done_a;

  sigrnd_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .e2        (e2),
    .f2        (f2),
    .RM_in     (RM_in),
    .db_in     (db_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_out     (s_out),
    .e3        (e3),
    .f3        (f3),
    .RM        (RM),
    .db        (db),
    .OVF       (OVF),
    .INX       (INX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic sg, input logic [10:0] ee, input logic [52:0] ff,
                              input logic [1:0] rm, input logic dbl, input logic ov,
                              input logic ix);
    exp_t r;
    r.s = sg; r.e3 = ee; r.f3 = ff; r.rm = rm; r.db = dbl; r.ovf = ov; r.inx = ix;
    return r;
  endfunction

  // Reference: integer add on the kept field, renormalize when it reaches the next power of 2.
  function automatic exp_t model(input logic sg, input logic [12:0] ex, input logic [54:0] fr,
                                 input logic [1:0] rm, input logic dbl);
    exp_t            r;
    longint unsigned k, lim;
    logic            l, g, st, up;
    int              e;
    if (dbl) begin
      k = 64'(fr[54:2]); l = fr[2]; g = fr[1]; st = fr[0]; lim = 64'd1 << 53;
    end else begin
      k = 64'(fr[54:31]); l = fr[31]; g = fr[30]; st = (fr[29:0] != 30'd0);
      lim = 64'd1 << 24;
    end
    case (rm)
      2'b11:   up = g & (l | st);
      2'b10:   up = 1'b0;
      2'b00:   up = ~sg & (g | st);
      default: up = sg & (g | st);
    endcase
    e = int'(ex);
    k = k + 64'(up);
    if (k >= lim) begin
      k = k >> 1;
      e = e + 1;
    end
    r.s   = sg;
    r.rm  = rm;
    r.db  = dbl;
    r.inx = g | st;
    r.ovf = dbl ? (e >= 2047) : (e >= 255);
    r.f3  = dbl ? 53'(k) : 53'(k << 29);
    r.e3  = dbl ? 11'(e) : 11'(e & 255);
    return r;
  endfunction

  function automatic exp_t cur_out();
    return mk(s_out, e3, f3, RM, db, OVF, INX);
  endfunction

  // Called at negedge+1; returns at negedge+1 after the accepting edge.
  task automatic send(input logic sg, input logic [12:0] ex, input logic [54:0] fr,
                      input logic [1:0] rm, input logic dbl, input exp_t ev);
    int n = 0;
    bit done = 1'b0;
    s = sg; e2 = ex; f2 = fr; RM_in = rm; db_in = dbl; in_valid = 1'b1;
    while (!done && n < 50) begin
      #1;
      if (in_ready) begin
        q.push_back(ev);
        done = 1'b1;
      end
      @(negedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 72'd1, 72'd0);
  endtask

  task automatic send_m(input logic sg, input logic [12:0] ex, input logic [54:0] fr,
                        input logic [1:0] rm, input logic dbl);
    send(sg, ex, fr, rm, dbl, model(sg, ex, fr, rm, dbl));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("drain_left", 72'(q.size()), 72'd0);
  endtask

  task automatic send_rand();
    logic        dbl, sg;
    logic [12:0] ex;
    logic [54:0] fr;
    logic [1:0]  rm;
    dbl = 1'($urandom_range(0, 1));
    sg  = 1'($urandom_range(0, 1));
    rm  = 2'($urandom_range(0, 3));
    ex  = dbl ? 13'($urandom_range(1, 2046)) : 13'($urandom_range(1, 254));
    fr  = 55'({$urandom(), $urandom()});
    send_m(sg, ex, fr, rm, dbl);
  endtask

  // Scoreboard and stall-stability monitor, sampled between edges.
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall && out_valid) chk("stall_hold", 72'(cur_out()), 72'(snap));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 72'd1, 72'd0);
        end else begin
          exp_t ev;
          ev = q.pop_front();
          chk("s_out", 72'(s_out), 72'(ev.s));
          chk("e3", 72'(e3), 72'(ev.e3));
          chk("f3", 72'(f3), 72'(ev.f3));
          chk("RM", 72'(RM), 72'(ev.rm));
          chk("db", 72'(db), 72'(ev.db));
          chk("OVF", 72'(OVF), 72'(ev.ovf));
          chk("INX", 72'(INX), 72'(ev.inx));
        end
      end
      stall = out_valid && !out_ready;
      snap  = cur_out();
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; s = 1'b0; e2 = '0; f2 = '0; RM_in = '0; db_in = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 72'(out_valid), 72'd0);
    chk("rst_in_ready", 72'(in_ready), 72'd1);
    chk("rst_f3", 72'(f3), 72'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_out_valid", 72'(out_valid), 72'd0);
    chk("post_rst_in_ready", 72'(in_ready), 72'd1);

    // Directed rounding cases
    send(1'b0, 13'd1023, {1'b1, 51'h0, 1'b0, 1'b1, 1'b0}, 2'b11, 1'b1,
         mk(1'b0, 11'd1023, 53'h10000000000000, 2'b11, 1'b1, 1'b0, 1'b1));
    send(1'b0, 13'd1023, {1'b1, 51'h0, 1'b1, 1'b1, 1'b0}, 2'b11, 1'b1,
         mk(1'b0, 11'd1023, 53'h10000000000002, 2'b11, 1'b1, 1'b0, 1'b1));
    send(1'b0, 13'd1000, {53'h1FFFFFFFFFFFFF, 1'b1, 1'b0}, 2'b00, 1'b1,
         mk(1'b0, 11'd1001, 53'h10000000000000, 2'b00, 1'b1, 1'b0, 1'b1));
    send(1'b0, 13'd254, {24'hFFFFFF, 1'b1, 30'h0}, 2'b11, 1'b0,
         mk(1'b0, 11'd255, 53'h10000000000000, 2'b11, 1'b0, 1'b1, 1'b1));
    send(1'b0, 13'd254, {24'hFFFFFF, 1'b1, 30'h0}, 2'b10, 1'b0,
         mk(1'b0, 11'd254, 53'h1FFFFFE0000000, 2'b10, 1'b0, 1'b0, 1'b1));
    send(1'b1, 13'd130, {24'h800000, 1'b0, 30'h1}, 2'b01, 1'b0,
         mk(1'b1, 11'd130, 53'h10000020000000, 2'b01, 1'b0, 1'b0, 1'b1));
    send(1'b1, 13'd130, {24'h800000, 1'b0, 30'h1}, 2'b00, 1'b0,
         mk(1'b1, 11'd130, 53'h10000000000000, 2'b00, 1'b0, 1'b0, 1'b1));
    send(1'b0, 13'd5, 55'h0, 2'b11, 1'b1,
         mk(1'b0, 11'd5, 53'h0, 2'b11, 1'b1, 1'b0, 1'b0));
    send(1'b0, 13'd2046, {53'h1FFFFFFFFFFFFF, 1'b1, 1'b0}, 2'b00, 1'b1,
         mk(1'b0, 11'h7FF, 53'h10000000000000, 2'b00, 1'b1, 1'b1, 1'b1));
    send(1'b0, 13'd1, {1'b0, 52'hFFFFFFFFFFFFF, 1'b1, 1'b0}, 2'b11, 1'b1,
         mk(1'b0, 11'd1, 53'h10000000000000, 2'b11, 1'b1, 1'b0, 1'b1));
    drain();

    // Backpressure: 6 back-to-back beats, out_ready low for 3 cycles
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand();
      end
      begin
        repeat (2) @(negedge clk);
        #2;
        chk("bp_in_ready_low", 72'(in_ready), 72'd0);
        chk("bp_out_valid", 72'(out_valid), 72'd1);
        @(negedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure
    done_a = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) send_rand();
        done_a = 1'b1;
      end
      begin
        while (!done_a) begin
          @(negedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send_rand();
    send_rand();
    #1;
    chk("mid_full_out_valid", 72'(out_valid), 72'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 72'(out_valid), 72'd0);
    chk("mid_rst_in_ready", 72'(in_ready), 72'd1);
    chk("mid_rst_data", 72'(cur_out()), 72'd0);
    q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    send(1'b1, 13'd100, {24'hABCDEF, 1'b1, 30'h0}, 2'b11, 1'b0,
         mk(1'b1, 11'd100, 53'h1579BE00000000, 2'b11, 1'b0, 1'b0, 1'b1));
    #1;
    chk("lat_one_cycle", 72'(out_valid), 72'd0);
    @(negedge clk);
    #2;
    chk("lat_two_cycles", 72'(out_valid), 72'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
